// File: rtl/data_repack_pkg.sv
// Shared types and width helpers for the data_repack_gearbox bit-stream repacker.
package data_repack_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_PAD   = 2'd2
    } state_e;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Twice the wider side so a full input word always fits behind a partial symbol.
    function automatic int acc_w(input int in_w, input int out_w);
        return 2 * max_w(in_w, out_w);
    endfunction

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/repack_acc.sv
// Accumulator datapath: LSB-aligned shift register with fill count; pop shifts out
// OUT_W bits, push inserts IN_W bits just above the bits that remain.
module repack_acc
    import data_repack_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 5,
    parameter int ACC_W  = acc_w(IN_W, OUT_W),
    parameter int FILL_W = $clog2(ACC_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [IN_W-1:0]   in_data_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic [FILL_W-1:0] fill_o,
    output logic [FILL_W-1:0] fill_next_o
);

    localparam logic [FILL_W-1:0] IN_FILL  = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_W);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [ACC_W-1:0]  ins_word;

    // Bits above fill are kept zero, so OR-insertion is safe and the pad symbol is zero-extended.
    always_comb begin
        ins_word               = '0;
        ins_word[IN_W-1:0]     = in_data_i;
        acc_d                  = pop_i ? (acc_q >> OUT_W) : acc_q;
        fill_d                 = pop_i ? (fill_q - OUT_FILL) : fill_q;
        if (push_i) begin
            acc_d  = acc_d | (ins_word << fill_d);
            fill_d = fill_d + IN_FILL;
        end
        if (clear_i) begin
            acc_d  = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign out_data_o  = acc_q[OUT_W-1:0];
    assign fill_o      = fill_q;
    assign fill_next_o = fill_d;

endmodule

// File: rtl/data_repack_gearbox.sv
// IN_W-to-OUT_W LSB-first gearbox with valid/ready on both sides.
// Build option DATA_REPACK_FLUSH_EN enables flush draining with a zero-padded last symbol.
module data_repack_gearbox
    import data_repack_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 5
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [IN_W-1:0]                            in_data,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [OUT_W-1:0]                           out_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    input  logic                                       flush,
    output logic                                       out_last,
    output logic [$clog2(acc_w(IN_W, OUT_W)+1)-1:0]    fill
);

    localparam int ACC_W  = acc_w(IN_W, OUT_W);
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam logic [FILL_W-1:0] IN_LIMIT = FILL_W'(ACC_W - IN_W);
    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_W);

    if (!width_ok(IN_W) || !width_ok(OUT_W)) begin : g_width_check
        $error("data_repack_gearbox: IN_W and OUT_W must lie in 1..32");
    end

    state_e            state_q;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              push, pop, clear;

    // Handshakes decode only registered state; out_ready never feeds in_ready.
    assign in_ready  = (state_q == S_RUN) && (fill_q <= IN_LIMIT);
    assign out_valid = (state_q == S_PAD) || (fill_q >= OUT_FILL);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign clear     = pop && (state_q == S_PAD);
    assign fill      = fill_q;

    repack_acc #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .ACC_W  (ACC_W),
        .FILL_W (FILL_W)
    ) u_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (clear),
        .in_data_i   (in_data),
        .out_data_o  (out_data),
        .fill_o      (fill_q),
        .fill_next_o (fill_d)
    );

`ifdef DATA_REPACK_FLUSH_EN
    // Flush decisions use the post-push/pop fill so a same-cycle push is covered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (flush && (fill_d != '0))
                        state_q <= (fill_d >= OUT_FILL) ? S_DRAIN : S_PAD;
                end
                S_DRAIN: begin
                    if (pop) begin
                        if (fill_d == '0)
                            state_q <= S_RUN;
                        else if (fill_d < OUT_FILL)
                            state_q <= S_PAD;
                    end
                end
                S_PAD: begin
                    if (pop)
                        state_q <= S_RUN;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign out_last = (state_q == S_PAD) || ((state_q == S_DRAIN) && (fill_q == OUT_FILL));
`else
    logic unused_flush_path;

    assign state_q           = S_RUN;
    assign out_last          = 1'b0;
    assign unused_flush_path = &{1'b0, flush, fill_d};
`endif

endmodule

// File: tb/tb_data_repack_gearbox.sv
// Scoreboard bench for data_repack_gearbox: an 8->5 instance checked through a symbol
// queue plus a 4->12 instance checked directly.
module tb_data_repack_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [7:0]  in_data_a;
    logic        in_valid_a, in_ready_a;
    logic [4:0]  out_data_a;
    logic        out_valid_a, out_ready_a, flush_a, out_last_a;
    logic [4:0]  fill_a;

    logic [3:0]  in_data_b;
    logic        in_valid_b, in_ready_b;
    logic [11:0] out_data_b;
    logic        out_valid_b, out_ready_b, flush_b, out_last_b;
    logic [4:0]  fill_b;

    data_repack_gearbox #(.IN_W(8), .OUT_W(5)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .flush     (flush_a),
        .out_last  (out_last_a),
        .fill      (fill_a)
    );

    data_repack_gearbox #(.IN_W(4), .OUT_W(12)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .flush     (flush_b),
        .out_last  (out_last_b),
        .fill      (fill_b)
    );

    typedef struct packed {
        logic [4:0] data;
        logic       last;
    } sym_t;

    sym_t exp_q[$];
    bit   bits_q[$];
    bit   model_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_sym(input logic [4:0] d, input logic l);
        sym_t s;
        s.data = d;
        s.last = l;
        exp_q.push_back(s);
    endtask

    // Monitor: pops the scoreboard on every accepted symbol and checks stall stability.
    initial begin
        sym_t       e, s;
        logic [4:0] held_data;
        logic       held_last;
        bit         held_valid;
        held_valid = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid) begin
                    check("stall_valid", 32'(out_valid_a), 32'd1);
                    check("stall_data", 32'(out_data_a), 32'(held_data));
                    check("stall_last", 32'(out_last_a), 32'(held_last));
                end
                if (out_valid_a && out_ready_a) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_symbol: got 0x%0h last=%0d, required no symbol",
                                 out_data_a, out_last_a);
                    end else begin
                        e = exp_q.pop_front();
                        check("sym_data", 32'(out_data_a), 32'(e.data));
                        check("sym_last", 32'(out_last_a), 32'(e.last));
                    end
                end
                held_valid = out_valid_a && !out_ready_a;
                held_data  = out_data_a;
                held_last  = out_last_a;
                if (model_en && in_valid_a && in_ready_a) begin
                    for (int i = 0; i < 8; i++) bits_q.push_back(in_data_a[i]);
                    while (bits_q.size() >= 5) begin
                        s.last = 1'b0;
                        for (int k = 0; k < 5; k++) s.data[k] = bits_q.pop_front();
                        exp_q.push_back(s);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_data_a  = d;
        in_valid_a = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid_a = 1'b0;
        check("push_a_accepted", 32'(ok), 32'd1);
    endtask

    task automatic push_b(input logic [3:0] d);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_data_b  = d;
        in_valid_b = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready_b;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid_b = 1'b0;
        check("push_b_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            tick(1);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        flush_a    = 1'b0;
        reset_n    = 1'b0;
        tick(2);
        exp_q.delete();
        bits_q.delete();
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, sent, cyc;
        reset_n     = 1'b0;
        in_data_a   = '0;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        flush_a     = 1'b0;
        in_data_b   = '0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        flush_b     = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data", 32'(out_data_a), 32'd0);
        check("rst_out_last", 32'(out_last_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_fill", 32'(fill_a), 32'd0);
        do_reset();

        // Directed 8->5 stream
        out_ready_a = 1'b1;
        expect_sym(5'h05, 1'b0); expect_sym(5'h05, 1'b0);
        expect_sym(5'h0F, 1'b0); expect_sym(5'h00, 1'b0);
        expect_sym(5'h1F, 1'b0); expect_sym(5'h07, 1'b0);
        expect_sym(5'h04, 1'b0); expect_sym(5'h10, 1'b0);
        push_a(8'hA5); push_a(8'h3C); push_a(8'hF0); push_a(8'h0F); push_a(8'h81);
        wait_drain("stream_drained");
        tick(2);
        check("stream_fill_end", 32'(fill_a), 32'd0);
        check("stream_valid_end", 32'(out_valid_a), 32'd0);

        // Backpressure: only two words fit while the sink is stalled
        do_reset();
        out_ready_a = 1'b0;
        cnt         = 0;
        in_data_a   = 8'hFF;
        in_valid_a  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (in_ready_a) cnt++;
            @(posedge clk);
            #1;
        end
        in_valid_a = 1'b0;
        check("bp_accepted", 32'(cnt), 32'd2);
        check("bp_fill", 32'(fill_a), 32'd16);
        check("bp_in_ready", 32'(in_ready_a), 32'd0);
        expect_sym(5'h1F, 1'b0); expect_sym(5'h1F, 1'b0); expect_sym(5'h1F, 1'b0);
        out_ready_a = 1'b1;
        tick(5);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_fill_after", 32'(fill_a), 32'd1);
        check("bp_in_ready_back", 32'(in_ready_a), 32'd1);

        // Flush behaviour
        do_reset();
        out_ready_a = 1'b1;
`ifdef DATA_REPACK_FLUSH_EN
        expect_sym(5'h1F, 1'b0);
        expect_sym(5'h07, 1'b1);
        push_a(8'hFF);
        flush_a = 1'b1;
        tick(1);
        flush_a = 1'b0;
        wait_drain("flush_drained");
        tick(1);
        check("flush_fill_end", 32'(fill_a), 32'd0);
        check("flush_in_ready", 32'(in_ready_a), 32'd1);
        flush_a = 1'b1;
        tick(1);
        flush_a = 1'b0;
        tick(3);
        check("flush_empty_valid", 32'(out_valid_a), 32'd0);
        check("flush_empty_fill", 32'(fill_a), 32'd0);
`else
        expect_sym(5'h1F, 1'b0);
        push_a(8'hFF);
        flush_a = 1'b1;
        tick(1);
        flush_a = 1'b0;
        tick(4);
        check("noflush_drained", 32'(exp_q.size()), 32'd0);
        check("noflush_fill_held", 32'(fill_a), 32'd3);
        check("noflush_valid", 32'(out_valid_a), 32'd0);
        expect_sym(5'h1F, 1'b0); expect_sym(5'h1F, 1'b0);
        push_a(8'hFF);
        wait_drain("noflush_more_drained");
        tick(1);
        check("noflush_fill_end", 32'(fill_a), 32'd1);
`endif

        // 4->12 instance: one symbol one cycle after the third nibble
        do_reset();
        push_b(4'h1);
        check("b_valid_after1", 32'(out_valid_b), 32'd0);
        push_b(4'h2);
        check("b_valid_after2", 32'(out_valid_b), 32'd0);
        push_b(4'h3);
        check("b_valid_after3", 32'(out_valid_b), 32'd1);
        check("b_data", 32'(out_data_b), 32'h321);
        tick(1);
        check("b_fill_end", 32'(fill_b), 32'd0);
        check("b_valid_end", 32'(out_valid_b), 32'd0);

        // Random handshakes against the bit-level model
        do_reset();
        model_en = 1'b1;
        sent     = 0;
        cyc      = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid_a  = ($urandom_range(0, 3) != 0);
            in_data_a   = 8'($urandom);
            out_ready_a = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid_a && in_ready_a) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        check("rand_words_sent", 32'(sent), 32'd1000);
        wait_drain("rand_drained");
        tick(1);
        check("rand_fill_end", 32'(fill_a), 32'd0);
        model_en = 1'b0;

        // Asynchronous reset while a symbol is pending
        do_reset();
        out_ready_a = 1'b1;
        expect_sym(5'h05, 1'b0);
        push_a(8'hA5);
        push_a(8'h3C);
        out_ready_a = 1'b0;
        check("mid_fill", 32'(fill_a), 32'd11);
        check("mid_valid", 32'(out_valid_a), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid_a), 32'd0);
        check("arst_out_data", 32'(out_data_a), 32'd0);
        check("arst_out_last", 32'(out_last_a), 32'd0);
        check("arst_in_ready", 32'(in_ready_a), 32'd1);
        check("arst_fill", 32'(fill_a), 32'd0);
        check("arst_pending", 32'(exp_q.size()), 32'd0);
        tick(2);
        reset_n     = 1'b1;
        tick(1);
        out_ready_a = 1'b1;
        expect_sym(5'h05, 1'b0);
        push_a(8'hA5);
        wait_drain("post_reset_drained");
        tick(1);
        check("post_reset_fill", 32'(fill_a), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
